trace_reorder_queue: RTL and testbench

- Synthesizable, parametrised event reorder queue for cosimulation and debug tracing.
- Pipeline stages retire events at different latencies. Each stage inserts its event at a fixed slot, chosen so that events leave the head in issue order.
- Sits between the core's writeback/store taps and the trace capture or debug output logic.
- Generalises the fixed seven-entry testbench queue: configurable depth, payload width and insert-port count, plus stall, invalidate, collision detection and occupancy.

---
 rtl/trace_reorder_queue_if.sv | 37 +++
 rtl/trace_reorder_queue.sv | 119 +++++++++++
 tb/tb_trace_reorder_queue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/trace_reorder_queue_if.sv
// Trace reorder queue bus: insert ports, rollback,
// error control and the registered head/status outputs.
interface trace_reorder_queue_if #(
  parameter int DATA_WIDTH       = 64,
  parameter int QUEUE_DEPTH      = 7,
  parameter int NUM_INSERT_PORTS = 3,
  parameter int SLOT_IDX_WIDTH   = $clog2(QUEUE_DEPTH),
  parameter int DROP_COUNT_WIDTH = 16,
  parameter int OCC_WIDTH        = $clog2(QUEUE_DEPTH + 1)
);
  logic                                     advance;
  logic [NUM_INSERT_PORTS-1:0]              insert_en;
  logic [NUM_INSERT_PORTS*SLOT_IDX_WIDTH-1:0] insert_slot;
  logic [NUM_INSERT_PORTS*DATA_WIDTH-1:0]   insert_data;
  logic                                     invalidate_en;
  logic [SLOT_IDX_WIDTH-1:0]                invalidate_slot;
  logic                                     clear_err;
  logic                                     out_valid;
  logic [DATA_WIDTH-1:0]                    out_data;
  logic [OCC_WIDTH-1:0]                     occupancy;
  logic                                     collision_err;
  logic [DROP_COUNT_WIDTH-1:0]              drop_count;

  modport master (
    output advance, insert_en, insert_slot, insert_data,
    output invalidate_en, invalidate_slot, clear_err,
    input  out_valid, out_data, occupancy,
    input  collision_err, drop_count
  );

  modport slave (
    input  advance, insert_en, insert_slot, insert_data,
    input  invalidate_en, invalidate_slot, clear_err,
    output out_valid, out_data, occupancy,
    output collision_err, drop_count
  );
endinterface

// File: rtl/trace_reorder_queue.sv
// Slot-addressed reorder queue: stages drop events into
// fixed slots so they leave the head in issue order.
module trace_reorder_queue #(
  parameter int DATA_WIDTH       = 64,
  parameter int QUEUE_DEPTH      = 7,
  parameter int NUM_INSERT_PORTS = 3,
  parameter int SLOT_IDX_WIDTH   = $clog2(QUEUE_DEPTH),
  parameter int DROP_COUNT_WIDTH = 16
) (
  input logic clk,
  input logic reset_n,
  trace_reorder_queue_if.slave q
);
  localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
  localparam int DRP_W = $clog2(NUM_INSERT_PORTS + 1);
  localparam int SUM_W = DROP_COUNT_WIDTH + DRP_W;
  localparam int IW    = SLOT_IDX_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam logic [IW:0] DEPTH_L = QUEUE_DEPTH[IW:0];

  typedef logic [IW-1:0] slot_t;
  typedef logic [DW-1:0] data_t;

  logic [QUEUE_DEPTH-1:0] vld_q;
  logic [QUEUE_DEPTH-1:0] vld_d;
  data_t dat_q [QUEUE_DEPTH];
  data_t dat_d [QUEUE_DEPTH];

  logic                        ov_q;
  data_t                       od_q;
  logic [OCC_W-1:0]            occ_q;
  logic [OCC_W-1:0]            occ_d;
  logic                        err_q;
  logic                        err_d;
  logic [DROP_COUNT_WIDTH-1:0] cnt_q;
  logic [DROP_COUNT_WIDTH-1:0] cnt_d;
  logic [DRP_W-1:0]            drops;
  logic [SUM_W-1:0]            sum;
  slot_t                       ins_s;

  function automatic logic in_range(slot_t s);
    return {1'b0, s} < DEPTH_L;
  endfunction

  // Next image: shift, then inserts, then invalidate
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    drops = '0;
    ins_s = '0;
    if (q.advance) begin
      vld_d = vld_q >> 1;
      for (int i = 0; i < QUEUE_DEPTH - 1; i++)
        dat_d[i] = dat_q[i+1];
    end
    for (int p = 0; p < NUM_INSERT_PORTS; p++) begin
      ins_s = q.insert_slot[p*IW +: IW];
      if (q.insert_en[p]) begin
        if (!in_range(ins_s) || vld_d[ins_s]) begin
          drops = drops + DRP_W'(1);
        end else begin
          vld_d[ins_s] = 1'b1;
          dat_d[ins_s] = q.insert_data[p*DW +: DW];
        end
      end
    end
    if (q.invalidate_en && in_range(q.invalidate_slot))
      vld_d[q.invalidate_slot] = 1'b0;
  end

  // Occupancy of the final next-state image
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      occ_d = occ_d + OCC_W'(vld_d[i]);
  end

  // Sticky error and saturating drop count; drops beat clear
  always_comb begin
    sum = q.clear_err ? '0 : SUM_W'(cnt_q);
    sum = sum + SUM_W'(drops);
    if (|sum[SUM_W-1:DROP_COUNT_WIDTH])
      cnt_d = '1;
    else
      cnt_d = sum[DROP_COUNT_WIDTH-1:0];
    err_d = (err_q & ~q.clear_err) | (drops != '0);
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      occ_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ov_q  <= q.advance & vld_q[0];
      if (q.advance)
        od_q <= dat_q[0];
      occ_q <= occ_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage, no reset needed
  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

  assign q.out_valid     = ov_q;
  assign q.out_data      = od_q;
  assign q.occupancy     = occ_q;
  assign q.collision_err = err_q;
  assign q.drop_count    = cnt_q;
endmodule

// File: tb/tb_trace_reorder_queue.sv
// Scoreboard bench for trace_reorder_queue: expected
// emissions are queued with the advancing edge they are due.
module tb_trace_reorder_queue;
  localparam int DW   = 64;
  localparam int DEP  = 7;
  localparam int NP   = 3;
  localparam int IW   = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  typedef struct {
    int          due;
    logic [63:0] d;
  } ev_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   adv_cnt;
  int   drops_now;
  int   e_cnt;
  bit   e_err;
  ev_t  sb[$];

  trace_reorder_queue_if #(
    .DATA_WIDTH(DW), .QUEUE_DEPTH(DEP),
    .NUM_INSERT_PORTS(NP), .SLOT_IDX_WIDTH(IW),
    .DROP_COUNT_WIDTH(CW)
  ) bus ();

  trace_reorder_queue #(
    .DATA_WIDTH(DW), .QUEUE_DEPTH(DEP),
    .NUM_INSERT_PORTS(NP), .SLOT_IDX_WIDTH(IW),
    .DROP_COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .q(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic put(int p, int s, logic [63:0] d, bit keep);
    int due;
    bus.insert_en[p] = 1'b1;
    bus.insert_slot[p*IW +: IW] = IW'(s);
    bus.insert_data[p*DW +: DW] = d;
    due = adv_cnt + (bus.advance ? 1 : 0) + s + 1;
    if (keep) sb.push_back('{due: due, d: d});
  endtask

  task automatic sb_kill(logic [63:0] d);
    int k;
    k = -1;
    foreach (sb[i]) if (sb[i].d == d) k = i;
    if (k >= 0) sb.delete(k);
  endtask

  task automatic tick();
    int  hit;
    int  occ;
    bit  a;
    a = bus.advance;
    @(posedge clk);
    if (a) adv_cnt++;
    if (bus.clear_err) begin
      e_err = 1'b0;
      e_cnt = 0;
    end
    if (drops_now > 0) begin
      e_err = 1'b1;
      e_cnt = (e_cnt + drops_now > CMAX) ? CMAX : e_cnt + drops_now;
    end
    #1;
    hit = -1;
    if (a) foreach (sb[i]) if (sb[i].due == adv_cnt) hit = i;
    if (hit >= 0) begin
      chk("out_valid", 64'(bus.out_valid), 64'd1);
      chk("out_data", bus.out_data, sb[hit].d);
      sb.delete(hit);
    end else begin
      chk("out_idle", 64'(bus.out_valid), 64'd0);
    end
    occ = 0;
    foreach (sb[i]) if (sb[i].due > adv_cnt) occ++;
    chk("occupancy", 64'(bus.occupancy), 64'(occ));
    chk("coll_err", 64'(bus.collision_err), 64'(e_err));
    chk("drop_cnt", 64'(bus.drop_count), 64'(e_cnt));
    bus.insert_en     = '0;
    bus.invalidate_en = 1'b0;
    bus.clear_err     = 1'b0;
    drops_now         = 0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    adv_cnt = 0;
    drops_now = 0;
    e_cnt = 0;
    e_err = 1'b0;
    reset_n = 1'b0;
    bus.advance = 1'b0;
    bus.insert_en = '0;
    bus.insert_slot = '0;
    bus.insert_data = '0;
    bus.invalidate_en = 1'b0;
    bus.invalidate_slot = '0;
    bus.clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_occ", 64'(bus.occupancy), 64'd0);
    chk("rst_cnt", 64'(bus.drop_count), 64'd0);
    reset_n = 1'b1;

    // reordering: A@4, then B@2 and C@4
    bus.advance = 1'b1;
    put(0, 4, 64'hA, 1);
    tick();
    put(0, 2, 64'hB, 1);
    put(1, 4, 64'hC, 1);
    tick();
    run(8);

    // port 0 beats port 1 on the same slot
    put(0, 3, 64'h11, 1);
    put(1, 3, 64'h22, 0);
    drops_now = 1;
    tick();
    // out-of-range slot
    put(2, 7, 64'h77, 0);
    drops_now = 1;
    tick();
    // occupied slot (0x11 now sits in slot 2)
    bus.advance = 1'b0;
    put(0, 2, 64'h33, 0);
    drops_now = 1;
    tick();
    bus.advance = 1'b1;
    run(6);

    // same-cycle insert and invalidate
    put(0, 4, 64'hD, 0);
    bus.invalidate_en = 1'b1;
    bus.invalidate_slot = 3'd4;
    tick();
    // empty-slot invalidate is harmless
    put(0, 5, 64'hE, 1);
    bus.invalidate_en = 1'b1;
    bus.invalidate_slot = 3'd1;
    tick();
    run(7);

    // invalidate slot 0 during advance: head still leaves
    put(0, 0, 64'h4E, 1);
    put(1, 1, 64'h1F, 1);
    tick();
    bus.invalidate_en = 1'b1;
    bus.invalidate_slot = 3'd0;
    sb_kill(64'h1F);
    tick();
    run(3);

    // stall: X@1 held five cycles
    bus.advance = 1'b0;
    put(0, 1, 64'h5A, 1);
    tick();
    run(4);
    bus.advance = 1'b1;
    run(4);

    // reset mid-run with slots 2,4,5 occupied
    put(0, 2, 64'h2, 1);
    put(1, 4, 64'h4, 1);
    put(2, 5, 64'h5, 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_occ", 64'(bus.occupancy), 64'd0);
    chk("mid_err", 64'(bus.collision_err), 64'd0);
    chk("mid_cnt", 64'(bus.drop_count), 64'd0);
    sb.delete();
    e_err = 1'b0;
    e_cnt = 0;
    #1;
    reset_n = 1'b1;
    run(10);

    // saturation: 3 drops per cycle, 21 total
    for (int c = 0; c < 7; c++) begin
      for (int p = 0; p < NP; p++) put(p, 7, 64'(p), 0);
      drops_now = 3;
      tick();
    end
    bus.clear_err = 1'b1;
    tick();
    // clear loses to a same-cycle drop
    bus.clear_err = 1'b1;
    put(0, 7, 64'h9, 0);
    drops_now = 1;
    tick();
    bus.clear_err = 1'b1;
    tick();
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
